// File: rtl/vram_access_arbiter.sv
// Video RAM access arbiter.
// Display scan-out reads have priority over queued CPU pixel writes. A
// starvation counter forces a write through once reads have denied the
// queue for STARVE_LIMIT grants in a row.
module vram_access_arbiter #(
   parameter int unsigned COL_W        = 8,
   parameter int unsigned ROW_W        = 8,
   parameter int unsigned COLOR_W      = 3,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cpu_wr_req,
   input  logic [COL_W-1:0]             cpu_col,
   input  logic [ROW_W-1:0]             cpu_row,
   input  logic [COLOR_W-1:0]           cpu_color,
   output logic                         cpu_stall,
   input  logic                         disp_rd_req,
   input  logic [COL_W-1:0]             disp_col,
   input  logic [ROW_W-1:0]             disp_row,
   output logic                         disp_rd_valid,
   output logic [COLOR_W-1:0]           disp_color_c,
   output logic                         disp_miss_c,
   output logic [ROW_W+COL_W-1:0]       ram_addr,
   output logic                         ram_we,
   output logic [COLOR_W-1:0]           ram_wdata,
   input  logic [COLOR_W-1:0]           ram_rdata,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         overflow
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;
   localparam int unsigned ADDR_W = ROW_W + COL_W;
   localparam int unsigned ENT_W  = ADDR_W + COLOR_W;
   localparam int unsigned SC_W   = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      GRANT_IDLE,
      GRANT_READ,
      GRANT_WRITE
   } grant_e;

   logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [SC_W-1:0]  starve_cnt;
   logic [SC_W-1:0]  starve_nxt;
   logic [LVL_W-1:0] level_nxt;
   logic [ENT_W-1:0] head;
   logic             rd_pend;
   logic             fifo_empty;
   logic             fifo_full;
   logic             starve_hit;
   logic             push;
   logic             pop;
   logic             drop;
   grant_e           grant;

   assign fifo_empty = (fifo_level == LVL_W'(0));
   assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
   assign starve_hit = (starve_cnt == SC_W'(STARVE_LIMIT));
   assign head       = fifo_mem[rd_ptr];

   // Per-cycle grant: queued write when display is quiet or writes are starved
   always_comb begin
      grant = GRANT_IDLE;
      if (!fifo_empty && (!disp_rd_req || starve_hit)) begin
         grant = GRANT_WRITE;
      end else if (disp_rd_req) begin
         grant = GRANT_READ;
      end
   end

   // FIFO push/pop decode, next level and next starvation count
   always_comb begin
      pop        = (grant == GRANT_WRITE);
      push       = cpu_wr_req && (!fifo_full || pop);
      drop       = cpu_wr_req && fifo_full && !pop;
      level_nxt  = fifo_level + LVL_W'(push) - LVL_W'(pop);
      starve_nxt = starve_cnt;
      if (fifo_empty || pop) begin
         starve_nxt = SC_W'(0);
      end else if ((grant == GRANT_READ) && !starve_hit) begin
         starve_nxt = starve_cnt + SC_W'(1);
      end
   end

   // A read only meets a write grant when the write was forced
   assign disp_miss_c  = pop && disp_rd_req;
   assign disp_color_c = disp_rd_valid ? ram_rdata : COLOR_W'(0);

   // Write FIFO storage; contents are don't-care until pushed
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {cpu_row, cpu_col, cpu_color};
      end
   end

   // FIFO pointers, level, stall, starvation counter and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         starve_cnt <= '0;
         cpu_stall  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         fifo_level <= level_nxt;
         starve_cnt <= starve_nxt;
         cpu_stall  <= (level_nxt == LVL_W'(FIFO_DEPTH));
         overflow   <= overflow || drop;
      end
   end

   // RAM command stage, one cycle after the grant; address holds when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         ram_we <= pop;
         if (pop) begin
            ram_addr  <= head[ENT_W-1:COLOR_W];
            ram_wdata <= head[COLOR_W-1:0];
         end else if (grant == GRANT_READ) begin
            ram_addr <= {disp_row, disp_col};
         end
      end
   end

   // Read-return valid pipeline matching the synchronous RAM latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend       <= 1'b0;
         disp_rd_valid <= 1'b0;
      end else begin
         rd_pend       <= (grant == GRANT_READ);
         disp_rd_valid <= rd_pend;
      end
   end

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench for vram_access_arbiter with a behavioural synchronous RAM.
module tb_vram_access_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_wr_req;
   logic [7:0]  cpu_col;
   logic [7:0]  cpu_row;
   logic [2:0]  cpu_color;
   logic        cpu_stall;
   logic        disp_rd_req;
   logic [7:0]  disp_col;
   logic [7:0]  disp_row;
   logic        disp_rd_valid;
   logic [2:0]  disp_color_c;
   logic        disp_miss_c;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [2:0]  ram_wdata;
   logic [2:0]  ram_rdata;
   logic [2:0]  fifo_level;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vram_access_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_wr_req(cpu_wr_req), .cpu_col(cpu_col), .cpu_row(cpu_row),
      .cpu_color(cpu_color), .cpu_stall(cpu_stall),
      .disp_rd_req(disp_rd_req), .disp_col(disp_col), .disp_row(disp_row),
      .disp_rd_valid(disp_rd_valid), .disp_color_c(disp_color_c),
      .disp_miss_c(disp_miss_c), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .fifo_level(fifo_level), .overflow(overflow)
   );

   // Synchronous RAM model: read-before-write, unwritten cells follow a pattern
   logic [2:0]  ram [int];
   logic [15:0] wlog_addr [$];
   logic [2:0]  wlog_data [$];

   function automatic logic [2:0] pat(input logic [15:0] a);
      case (a)
         16'h0A0B: pat = 3'd2;
         16'h0A0C: pat = 3'd5;
         16'h0A0D: pat = 3'd3;
         default:  pat = a[2:0];
      endcase
   endfunction

   always @(posedge clk) begin
      ram_rdata <= ram.exists(int'(ram_addr)) ? ram[int'(ram_addr)] : pat(ram_addr);
      if (ram_we === 1'b1) begin
         ram[int'(ram_addr)] = ram_wdata;
         wlog_addr.push_back(ram_addr);
         wlog_data.push_back(ram_wdata);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic [7:0] cc, input logic [7:0] cr,
                        input logic [2:0] ck, input logic rd, input logic [7:0] dc,
                        input logic [7:0] dr);
      cpu_wr_req  = wr;
      cpu_col     = cc;
      cpu_row     = cr;
      cpu_color   = ck;
      disp_rd_req = rd;
      disp_col    = dc;
      disp_row    = dr;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_we"},     32'(ram_we),        32'd0);
      chk({tag, "_addr"},   32'(ram_addr),      32'd0);
      chk({tag, "_wdata"},  32'(ram_wdata),     32'd0);
      chk({tag, "_valid"},  32'(disp_rd_valid), 32'd0);
      chk({tag, "_color"},  32'(disp_color_c),  32'd0);
      chk({tag, "_miss"},   32'(disp_miss_c),   32'd0);
      chk({tag, "_stall"},  32'(cpu_stall),     32'd0);
      chk({tag, "_level"},  32'(fifo_level),    32'd0);
      chk({tag, "_ovf"},    32'(overflow),      32'd0);
   endtask

   typedef struct {
      logic        wr;
      logic [7:0]  ccol;
      logic [7:0]  crow;
      logic [2:0]  ccolor;
      logic        rd;
      logic [7:0]  dcol;
      logic [7:0]  drow;
      logic        ewe;
      logic [15:0] eaddr;
      logic [2:0]  ewd;
      int          elvl;
      logic        evalid;
      logic [2:0]  ecolor;
   } vec_t;

   vec_t vecs [$];

   task automatic add(input logic wr, input logic [7:0] cc, input logic [7:0] cr,
                      input logic [2:0] ck, input logic rd, input logic [7:0] dc,
                      input logic [7:0] dr, input logic ewe, input logic [15:0] eaddr,
                      input logic [2:0] ewd, input int elvl, input logic evalid,
                      input logic [2:0] ecolor);
      vec_t v;
      v.wr = wr; v.ccol = cc; v.crow = cr; v.ccolor = ck;
      v.rd = rd; v.dcol = dc; v.drow = dr;
      v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd; v.elvl = elvl;
      v.evalid = evalid; v.ecolor = ecolor;
      vecs.push_back(v);
   endtask

   initial begin
      int base;
      int n;
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      #3;
      chk_all_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      cyc();

      // Single write, single read, read burst, then 9 writes across pointer wrap
      add(1, 8'd5,  8'd3,  3'd7, 0, 8'd0,  8'd0,  0, 16'h0000, 3'd0, 1, 0, 3'd0);
      add(0, 8'd0,  8'd0,  3'd0, 0, 8'd0,  8'd0,  1, 16'h0305, 3'd7, 0, 0, 3'd0);
      add(0, 8'd0,  8'd0,  3'd0, 1, 8'd11, 8'd10, 0, 16'h0A0B, 3'd0, 0, 0, 3'd0);
      add(0, 8'd0,  8'd0,  3'd0, 0, 8'd0,  8'd0,  0, 16'h0A0B, 3'd0, 0, 1, 3'd2);
      add(0, 8'd0,  8'd0,  3'd0, 0, 8'd0,  8'd0,  0, 16'h0A0B, 3'd0, 0, 0, 3'd0);
      add(0, 8'd0,  8'd0,  3'd0, 1, 8'd11, 8'd10, 0, 16'h0A0B, 3'd0, 0, 0, 3'd0);
      add(0, 8'd0,  8'd0,  3'd0, 1, 8'd12, 8'd10, 0, 16'h0A0C, 3'd0, 0, 1, 3'd2);
      add(0, 8'd0,  8'd0,  3'd0, 1, 8'd13, 8'd10, 0, 16'h0A0D, 3'd0, 0, 1, 3'd5);
      add(0, 8'd0,  8'd0,  3'd0, 0, 8'd0,  8'd0,  0, 16'h0A0D, 3'd0, 0, 1, 3'd3);
      add(0, 8'd0,  8'd0,  3'd0, 0, 8'd0,  8'd0,  0, 16'h0A0D, 3'd0, 0, 0, 3'd0);
      add(1, 8'h10, 8'h20, 3'd0, 0, 8'd0,  8'd0,  0, 16'h0A0D, 3'd0, 1, 0, 3'd0);
      for (int i = 1; i <= 8; i++) begin
         add(1, 8'(8'h10 + i), 8'(8'h20 + i), 3'(i), 0, 8'd0, 8'd0,
             1, {8'(8'h20 + i - 1), 8'(8'h10 + i - 1)}, 3'(i - 1), 1, 0, 3'd0);
      end
      add(0, 8'd0,  8'd0,  3'd0, 0, 8'd0,  8'd0,  1, 16'h2818, 3'd0, 0, 0, 3'd0);
      add(0, 8'd0,  8'd0,  3'd0, 0, 8'd0,  8'd0,  0, 16'h2818, 3'd0, 0, 0, 3'd0);

      foreach (vecs[i]) begin
         drive(vecs[i].wr, vecs[i].ccol, vecs[i].crow, vecs[i].ccolor,
               vecs[i].rd, vecs[i].dcol, vecs[i].drow);
         #1;
         chk($sformatf("v%0d_miss", i), 32'(disp_miss_c), 32'd0);
         cyc();
         chk($sformatf("v%0d_we", i),    32'(ram_we),        32'(vecs[i].ewe));
         chk($sformatf("v%0d_addr", i),  32'(ram_addr),      32'(vecs[i].eaddr));
         if (vecs[i].ewe)
            chk($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(vecs[i].ewd));
         chk($sformatf("v%0d_level", i), 32'(fifo_level),    32'(vecs[i].elvl));
         chk($sformatf("v%0d_stall", i), 32'(cpu_stall),     32'(vecs[i].elvl == 4));
         chk($sformatf("v%0d_valid", i), 32'(disp_rd_valid), 32'(vecs[i].evalid));
         if (vecs[i].evalid)
            chk($sformatf("v%0d_color", i), 32'(disp_color_c), 32'(vecs[i].ecolor));
      end

      // Continuous reads starve the queue: fill, overflow, forced write, resume
      base = wlog_addr.size();
      for (int k = 0; k <= 11; k++) begin
         int j;
         j = (k <= 4) ? k : 5;
         drive((k <= 4) || (k == 9), 8'(j), 8'h40, 3'(j + 1), 1, 8'(k), 8'h30);
         #1;
         chk($sformatf("starve%0d_miss", k), 32'(disp_miss_c), 32'(k == 9));
         cyc();
         if (k == 3) begin
            chk("full_stall", 32'(cpu_stall),  32'd1);
            chk("full_level", 32'(fifo_level), 32'd4);
            chk("full_ovf",   32'(overflow),   32'd0);
         end
         if (k == 4) begin
            chk("drop_ovf",   32'(overflow),   32'd1);
            chk("drop_level", 32'(fifo_level), 32'd4);
         end
         if (k == 9) begin
            chk("force_we",    32'(ram_we),        32'd1);
            chk("force_addr",  32'(ram_addr),      32'h4000);
            chk("force_wdata", 32'(ram_wdata),     32'd1);
            chk("force_level", 32'(fifo_level),    32'd4);
            chk("force_ovf",   32'(overflow),      32'd1);
            chk("force_valid", 32'(disp_rd_valid), 32'd1);
         end
         if (k == 10) begin
            chk("dropped_valid", 32'(disp_rd_valid), 32'd0);
            chk("resume_we",     32'(ram_we),        32'd0);
            chk("resume_addr",   32'(ram_addr),      32'h300A);
         end
         if (k == 11) begin
            chk("resume_valid", 32'(disp_rd_valid), 32'd1);
            chk("resume_color", 32'(disp_color_c),  32'd2);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      n = 0;
      while (fifo_level != 0 && n < 20) begin
         cyc();
         n++;
      end
      chk("drain_bound", 32'(n < 20), 32'd1);
      cyc();
      cyc();
      chk("drain_count", 32'(wlog_addr.size() - base), 32'd5);
      for (int m = 0; m < 5; m++) begin
         logic [7:0] ec;
         ec = (m < 4) ? 8'(m) : 8'd5;
         if (base + m < wlog_addr.size()) begin
            chk($sformatf("order%0d_addr", m), 32'(wlog_addr[base + m]), 32'({8'h40, ec}));
            chk($sformatf("order%0d_data", m), 32'(wlog_data[base + m]), 32'(3'(ec + 1)));
         end
      end
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // Asynchronous reset with writes queued and a read in flight
      drive(1, 8'd0, 8'h50, 3'd1, 1, 8'd0, 8'h31);
      cyc();
      drive(1, 8'd1, 8'h50, 3'd2, 1, 8'd1, 8'h31);
      cyc();
      drive(1, 8'd2, 8'h50, 3'd3, 1, 8'd2, 8'h31);
      cyc();
      chk("prerst_level", 32'(fifo_level), 32'd3);
      drive(0, 0, 0, 0, 1, 8'd3, 8'h31);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      base = wlog_addr.size();
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk($sformatf("postrst%0d_we", k),    32'(ram_we),        32'd0);
         chk($sformatf("postrst%0d_valid", k), 32'(disp_rd_valid), 32'd0);
         chk($sformatf("postrst%0d_level", k), 32'(fifo_level),    32'd0);
      end
      chk("postrst_nowrites", 32'(wlog_addr.size() - base), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
